maxpool_window_ctrl: RTL and testbench

MAXPOOL_WINDOW_CTRL -- requirements
Module: maxpool_window_ctrl

---
 rtl/maxpool_window_ctrl_if.sv | 29 ++
 rtl/maxpool_window_ctrl.sv | 92 +++++++++
 tb/tb_maxpool_window_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/maxpool_window_ctrl_if.sv
// Handshake and datapath-strobe bundle for the 2x2 max-pool window controller.
// slave is the controller side, master is the upstream/downstream/datapath side.
interface maxpool_window_ctrl_if #(
  parameter int WIDTH = 100
);
  localparam int AW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  logic          Start;
  logic          In_Valid;
  logic          In_Ready;
  logic          Out_Ready;
  logic          Out_Valid;
  logic          Pair_Ld;
  logic          Line_Wr_En;
  logic          Line_Rd_En;
  logic [AW-1:0] Line_Addr;
  logic          Busy;
  logic          Frame_Done;

  modport slave (
    input  Start, In_Valid, Out_Ready,
    output In_Ready, Out_Valid, Pair_Ld, Line_Wr_En, Line_Rd_En, Line_Addr, Busy, Frame_Done
  );

  modport master (
    output Start, In_Valid, Out_Ready,
    input  In_Ready, Out_Valid, Pair_Ld, Line_Wr_En, Line_Rd_En, Line_Addr, Busy, Frame_Done
  );
endinterface

// File: rtl/maxpool_window_ctrl.sv
// Control FSM for a streaming 2x2 max-pool: walks Col/Row over the frame, strobes the
// pair register and line buffer, and holds the pooled result until downstream takes it.
module maxpool_window_ctrl #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input logic                   Clk,
  input logic                   Rst,
  maxpool_window_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int AW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_valid;
  logic          frame_done;
  logic          in_ready;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          rd_en;

  // Reset gates the ready so nothing is accepted while Rst is held, even mid-RUN.
  assign in_ready = (state == RUN) && !Rst && !(out_valid && !bus.Out_Ready);
  assign accept   = bus.In_Valid && in_ready;
  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign rd_en    = accept && col[0] && row[0];

  assign bus.In_Ready   = in_ready;
  assign bus.Pair_Ld    = accept && !col[0];
  assign bus.Line_Wr_En = accept && col[0] && !row[0];
  assign bus.Line_Rd_En = rd_en;
  assign bus.Line_Addr  = AW'(col >> 1);
  assign bus.Out_Valid  = out_valid;
  assign bus.Busy       = (state != IDLE) && !Rst;
  assign bus.Frame_Done = frame_done;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A new result on the same edge as a take keeps Out_Valid high with no bubble.
      if (rd_en)
        out_valid <= 1'b1;
      else if (bus.Out_Ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= FLUSH;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (out_valid && bus.Out_Ready) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Randomized directed bench for maxpool_window_ctrl against a pixel-index reference model.
module tb_maxpool_window_ctrl;
  logic Clk;
  logic Rst;

  maxpool_window_ctrl_if #(.WIDTH(4))   if4 ();
  maxpool_window_ctrl_if #(.WIDTH(100)) ifd ();

  maxpool_window_ctrl #(.WIDTH(4), .HEIGHT(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(if4));
  maxpool_window_ctrl #(.WIDTH(100), .HEIGHT(100)) dutd (.Clk(Clk), .Rst(Rst), .bus(ifd));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   tests = 0;
  int   fails = 0;
  bit   sel   = 1'b0;  // 0: 4x4 instance, 1: default 100x100 instance

  // Reference model: frame phase (0 idle, 1 streaming, 2 draining), accepted-pixel index,
  // pending pooled result and the done pulse.
  int   m_phase = 0;
  int   m_k     = 0;
  bit   m_ov    = 1'b0;
  bit   m_fd    = 1'b0;
  bit   m_known = 1'b0;

  int   obs_pair, obs_wr, obs_xfer, obs_done, obs_addr_max, obs_wraps, prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    obs_pair = 0; obs_wr = 0; obs_xfer = 0; obs_done = 0;
    obs_addr_max = 0; obs_wraps = 0; prev_addr = 0;
  endtask

  task automatic step(input bit st, input bit iv, input bit ordy, input bit rs);
    int w, h, r, c;
    bit exp_ir, acc, rd_acc, nfd;
    logic o_ir, o_pair, o_wr, o_rd, o_ov, o_busy, o_fd;
    logic [31:0] o_addr;
    w = sel ? 100 : 4;
    h = sel ? 100 : 4;
    Rst = rs;
    if (sel) begin
      ifd.Start = st; ifd.In_Valid = iv; ifd.Out_Ready = ordy;
      if4.Start = 1'b0; if4.In_Valid = 1'b0; if4.Out_Ready = 1'b1;
    end else begin
      if4.Start = st; if4.In_Valid = iv; if4.Out_Ready = ordy;
      ifd.Start = 1'b0; ifd.In_Valid = 1'b0; ifd.Out_Ready = 1'b1;
    end
    @(negedge Clk);
    o_ir   = sel ? ifd.In_Ready   : if4.In_Ready;
    o_pair = sel ? ifd.Pair_Ld    : if4.Pair_Ld;
    o_wr   = sel ? ifd.Line_Wr_En : if4.Line_Wr_En;
    o_rd   = sel ? ifd.Line_Rd_En : if4.Line_Rd_En;
    o_ov   = sel ? ifd.Out_Valid  : if4.Out_Valid;
    o_busy = sel ? ifd.Busy       : if4.Busy;
    o_fd   = sel ? ifd.Frame_Done : if4.Frame_Done;
    o_addr = sel ? 32'(ifd.Line_Addr) : 32'(if4.Line_Addr);

    r = m_k / w;
    c = m_k % w;
    exp_ir = !rs && (m_phase == 1) && !(m_ov && !ordy);
    acc    = iv && exp_ir;
    rd_acc = acc && (c % 2 == 1) && (r % 2 == 1);

    chk("in_ready", o_ir, exp_ir);
    chk("pair_ld", o_pair, acc && (c % 2 == 0));
    chk("line_wr_en", o_wr, acc && (c % 2 == 1) && (r % 2 == 0));
    chk("line_rd_en", o_rd, rd_acc);
    chk("busy", o_busy, !rs && (m_phase != 0));
    if (m_known) begin
      chk("out_valid", o_ov, m_ov);
      chk("frame_done", o_fd, m_fd);
      chk("line_addr", o_addr, c / 2);
    end

    if (o_pair === 1'b1) obs_pair++;
    if (o_wr === 1'b1) obs_wr++;
    if (o_ov === 1'b1 && ordy) obs_xfer++;
    if (o_fd === 1'b1) obs_done++;
    if (int'(o_addr) > obs_addr_max) obs_addr_max = int'(o_addr);
    if (prev_addr == w / 2 - 1 && o_addr == 0) obs_wraps++;
    prev_addr = int'(o_addr);

    if (rs) begin
      m_phase = 0; m_k = 0; m_ov = 1'b0; m_fd = 1'b0; m_known = 1'b1;
    end else begin
      nfd  = (m_phase == 2) && m_ov && ordy;
      m_ov = rd_acc || (m_ov && !ordy);
      case (m_phase)
        0: if (st) begin m_phase = 1; m_k = 0; end
        1: if (acc) begin
             m_k++;
             if (m_k == w * h) begin m_k = 0; m_phase = 2; end
           end
        2: if (nfd) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_fd = nfd;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic stream(input int piv, input int por, input int pst, input int budget);
    int n;
    n = 0;
    while (m_phase != 0 && n < budget) begin
      step($urandom_range(0, 99) < pst, $urandom_range(0, 99) < piv,
           $urandom_range(0, 99) < por, 1'b0);
      n++;
    end
    chk("frame_end_busy", sel ? ifd.Busy : if4.Busy, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_frame_counts();
    int w, h;
    w = sel ? 100 : 4;
    h = sel ? 100 : 4;
    chk("out_transfers", obs_xfer, w * h / 4);
    chk("frame_done_cnt", obs_done, 1);
    chk("pair_ld_cnt", obs_pair, w * h / 2);
    chk("line_wr_cnt", obs_wr, w * h / 4);
  endtask

  task automatic run_frame(input int piv, input int por, input int pst, input int budget);
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    stream(piv, por, pst, budget);
    check_frame_counts();
  endtask

  initial begin
    Rst = 1'b1;
    if4.Start = 1'b0; if4.In_Valid = 1'b0; if4.Out_Ready = 1'b0;
    ifd.Start = 1'b0; ifd.In_Valid = 1'b0; ifd.Out_Ready = 1'b0;

    // 4x4: reset with inputs active, then one quiet cycle after reset.
    sel = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Full-rate frame: back-to-back results on odd rows.
    run_frame(100, 100, 0, 100);
    chk("busy_after_frame", if4.Busy, 1'b0);

    // Randomized frames with stray Start pulses during RUN.
    for (int f = 0; f < 4; f++) run_frame(70, 60, 15, 400);

    // Output stall: Out_Ready low for 5 cycles while a result is pending.
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !m_ov; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_ov_held", if4.Out_Valid, 1'b1);
    stream(100, 100, 0, 100);
    check_frame_counts();

    // Abandon a frame at Row=2, Col=1, then a clean frame with Start pulses mid-RUN.
    clear_counts();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 40 && m_k != 9; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abandon_busy", if4.Busy, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("abandon_no_done", obs_done, 0);
    run_frame(90, 90, 30, 200);

    // Default geometry: full frame with light backpressure.
    sel = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(90, 90, 5, 40000);
    chk("addr_max", obs_addr_max, 49);
    chk("addr_wraps", obs_wraps, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
